// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types, defaults and helpers for the bus arbiter
//
// Purpose: FSM state encoding, default bus widths and a constant clog2
// helper used to size index and counter fields.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_ACK    = 2'b10
  } arb_state_e;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  // Smallest r with (1 << r) >= value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin request picker
//
// Purpose: returns the first asserted request at or above ptr, wrapping
// from N_CLIENTS-1 back to 0.
// Ports:
//   req    in  N_CLIENTS  request vector
//   ptr    in  IDX_W      search start index (must be < N_CLIENTS)
//   winner out IDX_W      index of the selected request
//   valid  out 1          at least one request is asserted
module rr_priority_picker
  import bus_arb_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int IDX_W     = clog2(N_CLIENTS)
) (
  input  logic [N_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     winner,
  output logic                 valid
);

  always_comb begin
    int               idx;
    logic [IDX_W-1:0] cand;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    cand   = '0;
    // Walk from the farthest offset down to offset 0 so the closest
    // requester to ptr is the last one written and therefore wins.
    for (int k = N_CLIENTS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_CLIENTS) idx = idx - N_CLIENTS;
      cand = IDX_W'(idx);
      if (req[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter from N clients onto one slave port
//
// Purpose: grants one requesting client at a time, runs a single slave
// access for it and returns a registered one-cycle ack.
// Optional feature: define ARB_TIMEOUT_EN to abort an access after TIMEOUT
// ACCESS cycles without mem_ready and flag it on err.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rq, wr_ni           per-client request / direction (0 = write, 1 = read)
//   addr, wdata         packed per-client address / write data
//   ack, grant_id       one-hot acknowledge, current or last granted index
//   rdata, err          read data and timeout flag, valid with ack
//   mem_en, mem_we      slave access strobe / write enable
//   mem_addr, mem_wdata slave address / write data
//   mem_rdata, mem_ready slave read data / one-cycle completion
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TIMEOUT   = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CLIENTS-1:0]          rq,
  input  logic [N_CLIENTS-1:0]          wr_ni,
  input  logic [N_CLIENTS*ADDR_W-1:0]   addr,
  input  logic [N_CLIENTS*DATA_W-1:0]   wdata,
  output logic [N_CLIENTS-1:0]          ack,
  output logic [clog2(N_CLIENTS)-1:0]   grant_id,
  output logic [DATA_W-1:0]             rdata,
  output logic                          err,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_ready
);

  localparam int IDX_W = clog2(N_CLIENTS);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      grant_id_q, grant_id_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [N_CLIENTS-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;

  logic [IDX_W-1:0]      pick_winner;
  logic                  pick_valid;
  logic                  timeout;

  rr_priority_picker #(
    .N_CLIENTS (N_CLIENTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req    (rq),
    .ptr    (rr_ptr_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = clog2(TIMEOUT + 1);

  // Counts completed ACCESS cycles; it is zero whenever ACCESS is entered.
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d   = (state_q == ST_ACCESS) ? cnt_q + 1'b1 : '0;
  assign timeout = (state_q == ST_ACCESS) && !mem_ready &&
                   (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pick_valid) state_d = ST_ACCESS;
      ST_ACCESS: if (mem_ready || timeout) state_d = ST_ACK;
      ST_ACK:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, so ack/rdata/err
  // appear in the ACK cycle with no combinational path from the inputs.
  always_comb begin
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    mem_en_d    = (state_d == ST_ACCESS);
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_id_d  = pick_winner;
          mem_we_d    = ~wr_ni[pick_winner];
          mem_addr_d  = addr[pick_winner*ADDR_W +: ADDR_W];
          mem_wdata_d = wdata[pick_winner*DATA_W +: DATA_W];
        end
      end
      ST_ACCESS: begin
        if (mem_ready) begin
          if (!mem_we_q) rdata_d = mem_rdata;
          ack_d[grant_id_q] = 1'b1;
        end else if (timeout) begin
          err_d             = 1'b1;
          ack_d[grant_id_q] = 1'b1;
        end
      end
      ST_ACK: begin
        // Start the next search just past the client that was served.
        rr_ptr_d = (grant_id_q == IDX_W'(N_CLIENTS - 1)) ? '0 : grant_id_q + 1'b1;
      end
      default: ;
    endcase
  end

  assign ack       = ack_q;
  assign grant_id  = grant_id_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rq;
  logic [3:0]  wr_ni;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic [7:0]  rdata;
  logic        err;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .N_CLIENTS (4),
    .ADDR_W    (8),
    .DATA_W    (8),
    .TIMEOUT   (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rq        (rq),
    .wr_ni     (wr_ni),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .grant_id  (grant_id),
    .rdata     (rdata),
    .err       (err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  task automatic do_reset();
    rst       = 1'b0;
    rq        = '0;
    wr_ni     = '0;
    addr      = '0;
    wdata     = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [37:0] outs;
    do_reset();
    outs = {ack, grant_id, rdata, err, mem_en, mem_we, mem_addr, mem_wdata};
    checks++;
    if (outs !== 38'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0 || ack !== 4'b0) begin
      failures++;
      $display("FAIL reset_idle got mem_en=%b ack=%b exp 0/0000", mem_en, ack);
    end
  endtask

  task automatic test_client1_write();
    rq = 4'b0010; wr_ni = 4'b1101; addr[15:8] = 8'h3C; wdata[15:8] = 8'hA5;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, ack} !== {1'b1, 1'b1, 8'h3C, 8'hA5, 4'b0}) begin
      failures++;
      $display("FAIL wr_access got en=%b we=%b a=%h d=%h ack=%b exp 1 1 3c a5 0000",
               mem_en, mem_we, mem_addr, mem_wdata, ack);
    end
    @(negedge clk);
    checks++;
    if (ack !== 4'b0010 || grant_id !== 2'd1 || mem_en !== 1'b0) begin
      failures++;
      $display("FAIL wr_ack got ack=%b gid=%0d en=%b exp 0010 1 0", ack, grant_id, mem_en);
    end
    rq = 4'b0;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0) begin
      failures++;
      $display("FAIL wr_ack_one_cycle got=%b exp=0000", ack);
    end
  endtask

  task automatic test_client2_read();
    rq = 4'b0100; wr_ni = 4'b0100; mem_rdata = 8'h5A; mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || grant_id !== 2'd2) begin
      failures++;
      $display("FAIL rd_access got en=%b we=%b gid=%0d exp 1 0 2", mem_en, mem_we, grant_id);
    end
    @(negedge clk);
    checks++;
    if (ack !== 4'b0100 || rdata !== 8'h5A || err !== 1'b0) begin
      failures++;
      $display("FAIL rd_ack got ack=%b rdata=%h err=%b exp 0100 5a 0", ack, rdata, err);
    end
    rq = 4'b0;
    @(negedge clk);
    // A write from client 3 must leave rdata untouched.
    rq = 4'b1000; wr_ni = 4'b0111; mem_rdata = 8'hC3;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || grant_id !== 2'd3) begin
      failures++;
      $display("FAIL wr3_access got we=%b gid=%0d exp 1 3", mem_we, grant_id);
    end
    @(negedge clk);
    checks++;
    if (ack !== 4'b1000 || rdata !== 8'h5A) begin
      failures++;
      $display("FAIL wr3_rdata_hold got ack=%b rdata=%h exp 1000 5a", ack, rdata);
    end
    rq = 4'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5];
    int         exp_cyc [5];
    logic [3:0] got_seq [5];
    int         got_cyc [5];
    int         nacks;
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_cyc = '{2, 5, 8, 11, 14};
    nacks = 0;
    for (int i = 0; i < 5; i++) begin
      got_seq[i] = '0;
      got_cyc[i] = 0;
    end
    do_reset();
    rq = 4'b1111; wr_ni = 4'b1111; mem_rdata = 8'h40; mem_ready = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (ack !== 4'b0 && nacks < 5) begin
        got_seq[nacks] = ack;
        got_cyc[nacks] = c;
        nacks++;
      end
    end
    rq = 4'b0;
    checks++;
    if (nacks != 5) begin
      failures++;
      $display("FAIL rr_ack_count got=%0d exp=5", nacks);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got_seq[i] !== exp_seq[i] || got_cyc[i] != exp_cyc[i]) begin
        failures++;
        $display("FAIL rr_ack[%0d] got ack=%b cyc=%0d exp ack=%b cyc=%0d",
                 i, got_seq[i], got_cyc[i], exp_seq[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_delayed_ready();
    int bad;
    bad = 0;
    rq = 4'b0010; wr_ni = 4'b1101; addr[15:8] = 8'h11; wdata[15:8] = 8'h22;
    mem_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if ({mem_en, mem_we, ack, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0, 8'h11, 8'h22}) bad++;
      if (c == 1) begin
        addr = 32'hFFFF_FFFF; wdata = 32'hEEEE_EEEE; wr_ni = 4'b1111; rq = 4'b0001;
      end
      if (c == 5) mem_ready = 1'b1;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL delay_hold got bad_cycles=%0d exp=0", bad);
    end
    @(negedge clk);
    checks++;
    if (ack !== 4'b0010 || mem_en !== 1'b0) begin
      failures++;
      $display("FAIL delay_ack got ack=%b en=%b exp 0010 0", ack, mem_en);
    end
    mem_rdata = 8'h77;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL wrap_grant got en=%b gid=%0d exp 1 0", mem_en, grant_id);
    end
    @(negedge clk);
    checks++;
    if (ack !== 4'b0001 || rdata !== 8'h77) begin
      failures++;
      $display("FAIL wrap_ack got ack=%b rdata=%h exp 0001 77", ack, rdata);
    end
    rq = 4'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    rq = 4'b0100; wr_ni = 4'b1111; mem_rdata = 8'hEE; mem_ready = 1'b0;
`ifdef ARB_TIMEOUT_EN
    begin
      int ack_c;
      ack_c = 0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (c == 15) begin
          checks++;
          if (mem_en !== 1'b1 || ack !== 4'b0) begin
            failures++;
            $display("FAIL to_access got en=%b ack=%b exp 1 0000", mem_en, ack);
          end
        end
        if (ack !== 4'b0 && ack_c == 0) begin
          ack_c = c;
          checks++;
          if (ack !== 4'b0100 || err !== 1'b1 || rdata !== 8'h77) begin
            failures++;
            $display("FAIL to_ack got ack=%b err=%b rdata=%h exp 0100 1 77", ack, err, rdata);
          end
          rq = 4'b0;
        end
      end
      checks++;
      if (ack_c != 16) begin
        failures++;
        $display("FAIL to_latency got=%0d exp=16", ack_c);
      end
    end
`else
    begin
      int bad;
      bad = 0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (ack !== 4'b0 || err !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0 || mem_en !== 1'b1) begin
        failures++;
        $display("FAIL no_timeout got bad=%0d en=%b exp 0 1", bad, mem_en);
      end
    end
`endif
  endtask

  task automatic test_reset_abort();
    logic [37:0] outs;
    int          bad;
    bad = 0;
    rq = 4'b1000; wr_ni = 4'b0000; addr[31:24] = 8'h99; mem_ready = 1'b0;
    for (int i = 0; i < 6 && mem_en !== 1'b1; i++) @(negedge clk);
    checks++;
    if (mem_en !== 1'b1) begin
      failures++;
      $display("FAIL abort_setup got en=%b exp 1", mem_en);
    end
    #2 rst = 1'b0;
    #1;
    outs = {ack, grant_id, rdata, err, mem_en, mem_we, mem_addr, mem_wdata};
    checks++;
    if (outs !== 38'h0) begin
      failures++;
      $display("FAIL abort_outputs got=%h exp=0", outs);
    end
    @(negedge clk);
    rq = 4'b0; mem_ready = 1'b1; wr_ni = 4'b1111;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ack !== 4'b0 || mem_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abort_no_ack got bad=%0d exp=0", bad);
    end
    rq = 4'b1001;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL abort_ptr got en=%b gid=%0d exp 1 0", mem_en, grant_id);
    end
    @(negedge clk);
    checks++;
    if (ack !== 4'b0001) begin
      failures++;
      $display("FAIL abort_next_ack got=%b exp=0001", ack);
    end
    rq = 4'b0;
  endtask

  initial begin
    rst = 1'b0; rq = '0; wr_ni = '0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    test_reset();
    test_client1_write();
    test_client2_read();
    test_round_robin();
    test_delayed_ready();
    test_timeout();
    test_reset_abort();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

- Round-robin arbiter between N bus clients (each running client control logic) and one shared memory/slave port.
- Consumes each client's `rq`, `wr_ni`, address and write data; grants one client at a time.
- Drives the slave access and returns a one-cycle `ack` pulse to the granted client, which is what moves that client out of its wait-for-acknowledge state.

## Interface
Parameters:
- N_CLIENTS, 4, number of clients (2..16)
- ADDR_W, 8, address width
- DATA_W, 8, data width
- TIMEOUT, 15, max cycles waiting for mem_ready (used only with ARB_TIMEOUT_EN)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, asserted low
- rq  in  N_CLIENTS  per-client request, held high until ack
- wr_ni  in  N_CLIENTS  per-client direction: 0 = write, 1 = read
- addr  in  N_CLIENTS*ADDR_W  packed client addresses, client i at [i*ADDR_W +: ADDR_W]
- wdata  in  N_CLIENTS*DATA_W  packed client write data
- ack  out  N_CLIENTS  one-hot one-cycle acknowledge
- grant_id  out  $clog2(N_CLIENTS)  index of the current or last granted client
- rdata  out  DATA_W  read data, broadcast, valid in the ack cycle
- err  out  1  timeout flag, valid in the ack cycle (tied 0 without the macro)
- mem_en  out  1  slave access strobe
- mem_we  out  1  slave write enable
- mem_addr  out  ADDR_W  slave address
- mem_wdata  out  DATA_W  slave write data
- mem_rdata  in  DATA_W  slave read data
- mem_ready  in  1  slave completion, one cycle

## Operation
- FSM states: IDLE, ACCESS, ACK.
- IDLE
  - If `|rq`: pick the first requesting client at or after `rr_ptr`, searching upward with wrap.
  - Latch `grant_id`, `mem_addr`, `mem_wdata`, and `mem_we = ~wr_ni[winner]`; go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS
  - `mem_en = 1`; address, data and direction stay stable from the latched registers.
  - On `mem_ready = 1`: if a read, register `mem_rdata` into `rdata`; go to ACK.
- ACK
  - `ack[grant_id] = 1` for exactly one cycle; `mem_en = 0`.
  - `rr_ptr <= grant_id + 1`, wrapping N_CLIENTS-1 → 0; go to IDLE.
- rq is sampled only in IDLE. Changes on `rq`, `addr`, `wdata` or `wr_ni` during ACCESS or ACK have no effect.
- A write leaves `rdata` unchanged.
- Reset values:
  - state IDLE, `rr_ptr = 0`
  - ack, grant_id, rdata, err, mem_en, mem_we, mem_addr, mem_wdata all 0
- Reset asserted mid-transaction: abort immediately, all outputs go to reset values, no ack is issued. Clients are reset by the same signal.
- `mem_ready` outside ACCESS is ignored.
- Simultaneous requests: strict rotation. With all clients requesting from reset, the grant order is 0, 1, 2, …, N-1, 0.

## Timing
- `rq` high at rising edge k (FSM in IDLE) → `mem_en` high from edge k+1.
- `mem_ready` high at edge m (m ≥ k+2) → `ack`, `rdata` and `err` valid for the cycle following edge m.
- Minimum request-to-ack: 2 cycles. Back-to-back grants: one IDLE cycle between transactions, so throughput is 1 transaction per (3 + slave wait) cycles.
- `ack` is registered (no combinational path from `rq` to `ack`). The client sees `ack` and leaves its wait state at the next edge; its `rq` may still be high during the following IDLE cycle. The rotated `rr_ptr` prevents that client from being regranted ahead of any other requester.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT+1) runs in ACCESS.
  - If it reaches TIMEOUT with no `mem_ready`, go to ACK with `err = 1` and `rdata` unchanged.
  - The counter clears on entry to ACCESS.
- `ARB_TIMEOUT_EN` undefined: no counter; `err` is tied 0; ACCESS waits indefinitely.

## Structure
- Shared package `bus_arb_pkg`:
  - state encoding constants ST_IDLE = 2'b00, ST_ACCESS = 2'b01, ST_ACK = 2'b10
  - default ADDR_W/DATA_W constants
  - `clog2` helper
- Sub-module `rr_priority_picker`: combinational.
  - Inputs: `req[N_CLIENTS-1:0]`, `ptr`.
  - Outputs: `winner` index, `valid`.
  - Instantiated once inside bus_arbiter.
- Remaining logic (FSM, latches, timeout counter) lives in bus_arbiter.

## Test plan
- Client 1 write:
  - Stimulus: `rq = 4'b0010`, `wr_ni[1] = 0`, `addr = 8'h3C`, `wdata = 8'hA5`; `mem_ready` one cycle after `mem_en`.
  - Response: `mem_we = 1`, `mem_addr = 8'h3C`, `mem_wdata = 8'hA5`; `ack = 4'b0010` exactly one cycle, 2 cycles after `rq`; `grant_id = 1`.
- Client 2 read:
  - Stimulus: `wr_ni[2] = 1`, `mem_rdata = 8'h5A` with `mem_ready`.
  - Response: `mem_we = 0`; `rdata = 8'h5A` in the cycle where `ack = 4'b0100`.
- All four `rq` held high from reset, `mem_ready` always 1:
  - Response: ack sequence 0001, 0010, 0100, 1000, 0001; acks spaced 3 cycles apart.
- `mem_ready` delayed 5 cycles, with `addr`/`wdata` changed during ACCESS:
  - Response: `mem_addr`/`mem_wdata` hold the latched values; ack arrives 6 cycles after `rq`.
- `ARB_TIMEOUT_EN`, TIMEOUT = 15, `mem_ready` never asserted:
  - Response: ack with `err = 1` after 15 ACCESS cycles; without the macro, no ack and `err = 0`.
- Reset asserted (low) during ACCESS:
  - Response: `mem_en` and all outputs 0 immediately; after release, the FSM is in IDLE, `rr_ptr = 0`, and no ack is issued for the aborted transfer.
